// File: rtl/mbp_pkg.sv
// Shared types and default parameters for the multi-button press processor.
package mbp_pkg;
  typedef enum logic [1:0] {WAIT_REL, ARMED, HELD} mbp_state_e;

  localparam int NUM_BUTTONS_DEF     = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int FIFO_DEPTH_DEF      = 4;
endpackage

// File: rtl/mbp_debounce.sv
// One-channel debouncer; optional two-flop synchroniser when MULTI_BUTTON_SYNC_EN is defined.
module mbp_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic pending
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             din;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef MULTI_BUTTON_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign din = sync2_q;
  // A level still travelling through the synchroniser counts as unsettled.
  assign pending = (raw != deb_q) || (sync1_q != deb_q) || (sync2_q != deb_q);
`else
  assign din     = raw;
  assign pending = (din != deb_q);
`endif

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (din != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) deb_d = din;
      else                                      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb = deb_q;
endmodule

// File: rtl/multi_button_processor.sv
// Debounced button bank feeding a capture FSM and press-code FIFO.
// Define MULTI_BUTTON_SYNC_EN to insert a two-flop synchroniser per channel.
module multi_button_processor
  import mbp_pkg::*;
#(
  parameter int NUM_BUTTONS     = NUM_BUTTONS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
  localparam int CODE_W         = $clog2(NUM_BUTTONS),
  localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   player_wr,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic                   press_valid,
  output logic [CODE_W-1:0]      press_code,
  input  logic                   press_ready,
  output logic [CNT_W-1:0]       fifo_count,
  output logic                   multi_press,
  output logic                   overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [NUM_BUTTONS-1:0] ONE = 1;

  logic [NUM_BUTTONS-1:0] deb, pend;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    mbp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .raw     (buttons_raw[i]),
      .deb     (deb[i]),
      .pending (pend[i])
    );
  end

  mbp_state_e        state_q, state_d;
  logic              multi_q, multi_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [CODE_W-1:0] idx;
  logic              one_hot, push_req, push_ok, pop;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      if (deb[i]) idx = CODE_W'(i);
  end

  assign one_hot = (deb != '0) && ((deb & (deb - ONE)) == '0);
  assign pop     = (count_q != '0) && press_ready;

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    multi_d  = 1'b0;
    if (!player_wr) begin
      state_d = WAIT_REL;
    end else begin
      case (state_q)
        // Arm only once every channel is released and settled, so a button
        // held through reset cannot masquerade as a fresh press.
        WAIT_REL: if (deb == '0 && pend == '0) state_d = ARMED;
        ARMED: if (deb != '0) begin
          state_d = HELD;
          if (one_hot) push_req = 1'b1;
          else         multi_d  = 1'b1;
        end
        HELD:    if (deb == '0) state_d = ARMED;
        default: state_d = WAIT_REL;
      endcase
    end
  end

  always_comb begin
    push_ok  = push_req && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
    ovf_d    = push_req && !push_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_REL;
      multi_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      multi_q  <= multi_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked until a code is written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= idx;
  end

  assign press_valid = (count_q != '0);
  assign press_code  = press_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count  = count_q;
  assign multi_press = multi_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_multi_button_processor.sv
// Scoreboard bench for multi_button_processor at default parameters.
module tb_multi_button_processor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       player_wr = 1'b1;
  logic [3:0] buttons_raw = '0;
  logic       press_valid;
  logic [1:0] press_code;
  logic       press_ready = 1'b0;
  logic [2:0] fifo_count;
  logic       multi_press;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int mp_cnt = 0;
  int ov_cnt = 0;
  logic [1:0] exp_q [$];

  multi_button_processor dut (
    .clk         (clk),
    .rst         (rst),
    .player_wr   (player_wr),
    .buttons_raw (buttons_raw),
    .press_valid (press_valid),
    .press_code  (press_code),
    .press_ready (press_ready),
    .fifo_count  (fifo_count),
    .multi_press (multi_press),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Pop side of the scoreboard: a code leaves whenever valid && ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (multi_press) mp_cnt++;
      if (overflow)    ov_cnt++;
      if (press_valid && press_ready) begin
        logic [1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got code=%0d expected no pop", press_code);
        end else begin
          e = exp_q.pop_front();
          if (press_code !== e) begin
            errors++;
            $display("FAIL pop_code got=%0d expected=%0d", press_code, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int ch, input int hold, input int rel);
    buttons_raw = 4'(1 << ch);
    repeat (hold) tick();
    buttons_raw = '0;
    repeat (rel) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks += 5;
    if (press_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b expected=0", press_valid); end
    if (press_code !== 2'd0)  begin errors++; $display("FAIL rst_code got=%0d expected=0", press_code); end
    if (fifo_count !== 3'd0)  begin errors++; $display("FAIL rst_count got=%0d expected=0", fifo_count); end
    if (multi_press !== 1'b0) begin errors++; $display("FAIL rst_multi got=%b expected=0", multi_press); end
    if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_ovf got=%b expected=0", overflow); end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_latency();
    press_ready = 1'b0;
    buttons_raw = 4'b0100;
    exp_q.push_back(2'd2);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (press_valid !== (k >= 5)) begin
        errors++;
        $display("FAIL latency_valid edge=%0d got=%b expected=%b", k, press_valid, (k >= 5));
      end
      if (k == 5) begin
        checks += 2;
        if (press_code !== 2'd2) begin errors++; $display("FAIL latency_code got=%0d expected=2", press_code); end
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL latency_count got=%0d expected=1", fifo_count); end
      end
    end
    buttons_raw = '0;
    repeat (6) tick();
    press_ready = 1'b1;
    repeat (3) tick();
    press_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL latency_drain got=%0d expected=0", fifo_count); end
  endtask

  task automatic test_bounce();
    int mp0 = mp_cnt;
    for (int k = 0; k < 20; k++) begin
      buttons_raw = ((k / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL bounce_count cyc=%0d got=%0d expected=0", k, fifo_count); end
    end
    buttons_raw = '0;
    repeat (6) tick();
    checks++;
    if (mp_cnt != mp0) begin errors++; $display("FAIL bounce_multi got=%0d expected=%0d", mp_cnt, mp0); end
  endtask

  task automatic test_multi();
    int mp0 = mp_cnt;
    buttons_raw = 4'b0011;
    repeat (10) tick();
    checks += 2;
    if (mp_cnt != mp0 + 1)   begin errors++; $display("FAIL multi_pulse got=%0d expected=%0d", mp_cnt - mp0, 1); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL multi_count got=%0d expected=0", fifo_count); end
    buttons_raw = '0;
    repeat (8) tick();
    exp_q.push_back(2'd1);
    buttons_raw = 4'b0010;
    repeat (10) tick();
    checks += 2;
    if (press_valid !== 1'b1) begin errors++; $display("FAIL multi_after_valid got=%b expected=1", press_valid); end
    if (press_code !== 2'd1)  begin errors++; $display("FAIL multi_after_code got=%0d expected=1", press_code); end
    buttons_raw = '0;
    repeat (6) tick();
    press_ready = 1'b1;
    repeat (3) tick();
    press_ready = 1'b0;
  endtask

  task automatic test_player_wr();
    player_wr = 1'b0;
    press(0, 10, 7);
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL nowr_count got=%0d expected=0", fifo_count); end
    player_wr = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_overflow();
    int ov0 = ov_cnt;
    press_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) exp_q.push_back(2'(c));
      press(c % 4, 8, 7);
    end
    checks += 3;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d expected=4", fifo_count); end
    if (ov_cnt != ov0 + 1)   begin errors++; $display("FAIL ovf_pulses got=%0d expected=1", ov_cnt - ov0); end
    if (press_code !== 2'd0) begin errors++; $display("FAIL ovf_head got=%0d expected=0", press_code); end
    press_ready = 1'b1;
    repeat (6) tick();
    press_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL ovf_drain got=%0d expected=0", fifo_count); end
  endtask

  task automatic test_full_pop();
    int ov0;
    press_ready = 1'b0;
    for (int c = 3; c >= 0; c--) begin
      exp_q.push_back(2'(c));
      press(c, 8, 7);
    end
    ov0 = ov_cnt;
    exp_q.push_back(2'd2);
    buttons_raw = 4'b0100;
    repeat (4) tick();
    checks++;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_pre_count got=%0d expected=4", fifo_count); end
    press_ready = 1'b1;
    tick();
    press_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count got=%0d expected=4", fifo_count); end
    repeat (3) tick();
    buttons_raw = '0;
    repeat (7) tick();
    checks++;
    if (ov_cnt != ov0) begin errors++; $display("FAIL full_ovf got=%0d expected=0", ov_cnt - ov0); end
    press_ready = 1'b1;
    repeat (8) tick();
    press_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL full_drain got=%0d expected=0", fifo_count); end
  endtask

  task automatic test_reset_held();
    press_ready = 1'b1;
    exp_q.push_back(2'd3);
    buttons_raw = 4'b1000;
    repeat (8) tick();
    #3 rst = 1'b1;
    #1;
    checks += 5;
    if (press_valid !== 1'b0) begin errors++; $display("FAIL rsth_valid got=%b expected=0", press_valid); end
    if (press_code !== 2'd0)  begin errors++; $display("FAIL rsth_code got=%0d expected=0", press_code); end
    if (fifo_count !== 3'd0)  begin errors++; $display("FAIL rsth_count got=%0d expected=0", fifo_count); end
    if (multi_press !== 1'b0) begin errors++; $display("FAIL rsth_multi got=%b expected=0", multi_press); end
    if (overflow !== 1'b0)    begin errors++; $display("FAIL rsth_ovf got=%b expected=0", overflow); end
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++;
      if (press_valid !== 1'b0) begin errors++; $display("FAIL rsth_held cyc=%0d got=%b expected=0", k, press_valid); end
    end
    buttons_raw = '0;
    repeat (8) tick();
    exp_q.push_back(2'd3);
    press(3, 8, 7);
    press_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_multi();
    test_player_wr();
    test_overflow();
    test_full_pop();
    test_reset_held();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d entries expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
